// File: rtl/fp_mul_result_fifo.sv
// In-order result queue behind the FP32 multiplier: buffers {product, ovrf, udrf},
// classifies the head entry and accumulates sticky exception flags until software clears them.
module fp_mul_result_fifo #(
    parameter int DEPTH = 4,                   // power of 2, at least 2
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [31:0]   fp_Z,
    input  logic          ovrf,
    input  logic          udrf,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [31:0]   out_data,
    output logic          out_ovrf,
    output logic          out_udrf,
    output logic [1:0]    out_class,
    output logic [CW-1:0] count,
    output logic [1:0]    fflags,
    input  logic          fflags_clr
);

    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
        logic [31:0] data;
        logic        ovrf;
        logic        udrf;
    } entry_t;

    typedef enum logic [1:0] {
        CLS_NORMAL = 2'b00,
        CLS_ZERO   = 2'b01,
        CLS_INF    = 2'b10,
        CLS_NAN    = 2'b11
    } fp_class_e;

    entry_t        mem [DEPTH];
    entry_t        head;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          enq;
    logic          deq;
    logic [7:0]    head_exp;
    logic [22:0]   head_frac;

    // Status comes only from registered count, so in_ready never depends on out_ready.
    assign in_ready  = (count != CW'(DEPTH));
    assign out_valid = (count != '0);
    assign enq       = in_valid && in_ready;
    assign deq       = out_valid && out_ready;

    // NOTE: storage is cleared on reset so the head reads as zero, not stale data, after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (enq) begin
            mem[wr_ptr] <= {fp_Z, ovrf, udrf};
        end
    end

    // NOTE: every state register uses non-blocking assignment so all updates see pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            fflags <= 2'b00;
        end else begin
            if (enq) wr_ptr <= wr_ptr + AW'(1);
            if (deq) rd_ptr <= rd_ptr + AW'(1);
            case ({enq, deq})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            // A clear coinciding with an enqueue keeps the incoming flags.
            fflags <= (fflags_clr ? 2'b00 : fflags) | ({ovrf, udrf} & {2{enq}});
        end
    end

    assign head      = mem[rd_ptr];
    assign out_data  = head.data;
    assign out_ovrf  = head.ovrf;
    assign out_udrf  = head.udrf;
    assign head_exp  = head.data[30:23];
    assign head_frac = head.data[22:0];

    // NOTE: out_class gets a default before the decode so no latch can be inferred.
    always_comb begin
        out_class = CLS_NORMAL;
        if (head_exp == 8'h00 && head_frac == '0) begin
            out_class = CLS_ZERO;
        end else if (head_exp == 8'hFF) begin
            out_class = (head_frac == '0) ? CLS_INF : CLS_NAN;
        end
    end

endmodule

// File: doc/fp_mul_result_fifo.md
Name: fp_mul_result_fifo

Overview:
- Downstream stage of the combinational FP32 multiplier.
- Captures each product fp_Z with its ovrf/udrf flags into a small in-order queue, using a valid/ready handshake to decouple the multiplier from the writeback consumer.
- Classifies the entry at the head of the queue.
- Keeps sticky accrued exception flags that software clears.

Parameters:
- DEPTH, 4, number of queue entries; must be a power of 2 and at least 2.
- CW, $clog2(DEPTH+1), width of the occupancy counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous reset, active-high.
- in_valid  in  1  the multiplier result on fp_Z/ovrf/udrf is valid.
- in_ready  out  1  the queue can accept an entry this cycle.
- fp_Z  in  32  FP32 product from the multiplier.
- ovrf  in  1  overflow flag from the multiplier.
- udrf  in  1  underflow flag from the multiplier.
- out_valid  out  1  the head entry is valid.
- out_ready  in  1  the consumer accepts the head entry.
- out_data  out  32  FP32 value of the head entry.
- out_ovrf  out  1  overflow flag of the head entry.
- out_udrf  out  1  underflow flag of the head entry.
- out_class  out  2  head classification: 00 normal/subnormal, 01 ±zero, 10 ±inf, 11 NaN.
- count  out  CW  number of occupied entries.
- fflags  out  2  sticky flags {OF, UF}.
- fflags_clr  in  1  synchronous clear of fflags.

Behaviour:
- Reset (async assert, any time, including mid-transfer):
  - wr_ptr=0, rd_ptr=0, count=0, fflags=2'b00.
  - Every storage entry is cleared to 0.
  - Resulting outputs: out_valid=0, out_data=0, out_ovrf=0, out_udrf=0, out_class=01, in_ready=1.
  - In-flight entries are discarded.
- Enqueue: fires on in_valid && in_ready.
  - {fp_Z, ovrf, udrf} is written at wr_ptr.
  - wr_ptr advances by 1 modulo DEPTH (natural wrap).
- Dequeue: fires on out_valid && out_ready.
  - rd_ptr advances by 1 modulo DEPTH.
- Status signals:
  - in_ready = (count != DEPTH). It is registered-state-derived only and has no combinational dependence on out_ready.
  - out_valid = (count != 0).
  - out_data, out_ovrf, out_udrf and out_class are driven combinationally from the entry at rd_ptr.
- Latency: there is no fall-through. A word enqueued at edge N is visible on out_* after edge N, so the consumer can take it in cycle N+1 at the earliest.
- Count update:
  - +1 on enqueue only.
  - -1 on dequeue only.
  - Unchanged on a simultaneous enqueue and dequeue.
- Boundary conditions:
  - Full: in_ready=0. A dequeue in that cycle does not enable an enqueue in the same cycle.
  - Empty: out_valid=0; out_ready is ignored and the pointers hold.
  - in_valid while full: the entry is not taken, and the producer must hold it.
  - fp_Z/ovrf/udrf are sampled only on an enqueue.
- out_class decode of the head entry, with e = bits[30:23] and f = bits[22:0]:
  - e==0 and f==0 → 01.
  - e==FF and f==0 → 10.
  - e==FF and f!=0 → 11.
  - Otherwise → 00.
- fflags:
  - On each enqueue: OF |= ovrf and UF |= udrf.
  - fflags_clr clears both bits at the next edge.
  - If clear and an enqueue with a set flag occur in the same cycle, the new flag wins: result = incoming flags, with nothing lost.
  - Flags are never set by non-enqueued inputs.
- Safety: the pointers never over- or under-run; count stays within 0..DEPTH at all times.

Test Plan:
- Reset, then enqueue fp_Z=32'h41100000 (ovrf=0, udrf=0) → count=1 next cycle; out_valid=1, out_data=32'h41100000, out_class=00; fflags=00.
- Enqueue 4 values with out_ready=0 → count=4, in_ready=0. A 5th in_valid is not accepted. Drain 4 → the data comes out in order and count returns to 0.
- Steady stream with in_valid=1 and out_ready=1 for 10 cycles (DEPTH=4) → after the first cycle, count holds at 1 and one word per cycle is delivered in order. Pointers wrap with no loss or duplication.
- Enqueue 32'h7F800000 with ovrf=1, then 32'h80000000 with udrf=1 → out_class shows 10 then 01; fflags=11 persists after both are dequeued.
- fflags=11, then fflags_clr=1 in the same cycle as an enqueue with udrf=1, ovrf=0 → fflags=01.
- Queue holding 3 entries, assert rst asynchronously mid-cycle → out_valid=0, count=0, out_data=0, fflags=00 immediately. After release, the first enqueued word appears at the head.
